// File: rtl/fft_pkg.sv
// Shared types for the FFT frame loader: FSM state encoding, address width helper, frame counter width.
package fft_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    LOAD,
    WAIT_FFT,
    GAP
  } state_t;

  localparam int FRAME_CNT_W = 8;

  function automatic int ADDR_W(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fft_bitrev.sv
// Bit-reversal of a W-bit index; purely combinational, zero latency, no flow control.
module fft_bitrev #(
  parameter int W = 3
) (
  input  logic [W-1:0] i_in,
  output logic [W-1:0] o_out
);

  for (genvar b = 0; b < W; b++) begin : g_rev
    assign o_out[b] = i_in[W-1-b];
  end

endmodule

// File: rtl/fft_frame_loader.sv
// Collects N samples per frame into the FFT input RAM (write strobe 1 cycle after accept), waits for fft_finish.
// Source is stalled outside LOAD; optional BITREV_ADDR_EN writes samples at bit-reversed addresses.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int N           = 8,
  parameter int MSB         = 16,
  parameter int START_DELAY = 4,
  parameter int FRAME_GAP   = 16,
  parameter int FFT_TIMEOUT = 4096
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic                       i_continuous,
  input  logic                       i_stop,
  input  logic [MSB-1:0]             i_sample_in,
  input  logic                       i_sample_valid,
  output logic                       o_sample_ready,
  output logic [MSB-1:0]             o_data_out,
  output logic [ADDR_W(N)-1:0]       o_addr,
  output logic                       o_insert_data,
  input  logic                       i_fft_finish,
  output logic                       o_frame_done,
  output logic                       o_busy,
  output logic [FRAME_CNT_W-1:0]     o_frame_count,
  output logic                       o_timeout_err
);

  localparam int AW    = ADDR_W(N);
  localparam int DLY_W = $clog2(START_DELAY + 2);
  localparam int GAP_W = $clog2(FRAME_GAP + 2);
  localparam int TMO_W = $clog2(FFT_TIMEOUT + 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [AW-1:0]          r_idx;
  logic [DLY_W-1:0]       r_dly_cnt;
  logic [GAP_W-1:0]       r_gap_cnt;
  logic [TMO_W-1:0]       r_tmo_cnt;
  logic                   r_cont;
  logic                   r_stop_pend;
  logic                   r_ins;
  logic [MSB-1:0]         r_dat;
  logic [AW-1:0]          r_addr;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic                   r_tmo_err;

  logic                   w_accept;
  logic                   w_last;
  logic                   w_dly_done;
  logic                   w_gap_done;
  logic                   w_tmo_hit;
  logic                   w_rearm;
  logic [AW-1:0]          w_addr_map;

  assign w_accept   = (r_state == LOAD) && i_sample_valid;
  assign w_last     = w_accept && (r_idx == AW'(N - 1));
  assign w_dly_done = (r_dly_cnt == DLY_W'(START_DELAY - 1));
  assign w_gap_done = (r_gap_cnt == GAP_W'(FRAME_GAP - 1));
  assign w_tmo_hit  = (r_tmo_cnt == TMO_W'(FFT_TIMEOUT - 1));
  // A stop arriving in the very cycle fft_finish lands must also end the stream.
  assign w_rearm    = r_cont && !(r_stop_pend || i_stop);

`ifdef BITREV_ADDR_EN
  fft_bitrev #(.W(AW)) u_bitrev (
    .i_in  (r_idx),
    .o_out (w_addr_map)
  );
`else
  assign w_addr_map = r_idx;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (i_start) w_next = (START_DELAY == 0) ? LOAD : DELAY;
      DELAY:    if (w_dly_done) w_next = LOAD;
      LOAD:     if (w_last) w_next = WAIT_FFT;
      WAIT_FFT: begin
        if (i_fft_finish)   w_next = w_rearm ? ((FRAME_GAP == 0) ? LOAD : GAP) : IDLE;
        else if (w_tmo_hit) w_next = IDLE;
      end
      GAP: begin
        if (i_stop)          w_next = IDLE;
        else if (w_gap_done) w_next = LOAD;
      end
      default:  w_next = IDLE;
    endcase
  end

  always_comb begin
    o_sample_ready = (r_state == LOAD);
    o_busy         = (r_state != IDLE);
    o_frame_done   = (r_state == WAIT_FFT) && i_fft_finish;
    o_insert_data  = r_ins;
    o_data_out     = r_dat;
    o_addr         = r_addr;
    o_frame_count  = r_frame_cnt;
    o_timeout_err  = r_tmo_err;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx       <= '0;
      r_dly_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_cont      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_ins       <= 1'b0;
      r_dat       <= '0;
      r_addr      <= '0;
      r_frame_cnt <= '0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_ins <= w_accept;
      if (w_accept) begin
        r_dat  <= i_sample_in;
        r_addr <= w_addr_map;
        r_idx  <= w_last ? '0 : r_idx + AW'(1);
      end

      // Counters sit at zero outside their state, so each restarts on entry.
      r_dly_cnt <= (r_state == DELAY)    ? r_dly_cnt + DLY_W'(1) : '0;
      r_gap_cnt <= (r_state == GAP)      ? r_gap_cnt + GAP_W'(1) : '0;
      r_tmo_cnt <= (r_state == WAIT_FFT) ? r_tmo_cnt + TMO_W'(1) : '0;

      if (r_state == IDLE && i_start) r_cont <= i_continuous;

      if (r_state != IDLE && w_next == IDLE)
        r_stop_pend <= 1'b0;
      else if (i_stop && (r_state == DELAY || r_state == LOAD || r_state == WAIT_FFT))
        r_stop_pend <= 1'b1;

      if (r_state == IDLE && i_start)
        r_tmo_err <= 1'b0;
      else if (r_state == WAIT_FFT && !i_fft_finish && w_tmo_hit)
        r_tmo_err <= 1'b1;

      if (r_state == WAIT_FFT && i_fft_finish) r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
    end
  end

endmodule
